// File: rtl/dsc_cas_pkg.sv
// Shared types and constants for the deterministic unary compare-and-swap blocks.
// Optional feature macro used by this family: DSC_CAS_EARLY_TERM_EN.
package dsc_cas_pkg;

  localparam int BITS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One unary frame spans 2**bits cycles.
  function automatic int unsigned FRAME_LEN(input int unsigned bits);
    return 32'd1 << bits;
  endfunction

endpackage

// File: rtl/dsc_unary_gen.sv
// Shared frame counter and the two thermometer comparators that turn binary
// operands into unary streams; reusable by the other dsc arithmetic blocks.
module dsc_unary_gen
  import dsc_cas_pkg::*;
#(
  parameter int BITS = BITS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic            sn_a,
  output logic            sn_b,
  output logic            last
);

  logic [BITS-1:0] ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (clr)
      ctr_d = '0;
    else if (en)
      ctr_d = ctr_q + BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      ctr_q <= '0;
    else
      ctr_q <= ctr_d;
  end

  assign sn_a = (a > ctr_q);
  assign sn_b = (b > ctr_q);
  assign last = &ctr_q;

endmodule

// File: rtl/dsc_cas_seq.sv
// Sequential compare-and-swap in the unary domain: max = OR of streams, min = AND.
// Define DSC_CAS_EARLY_TERM_EN to end the frame once both streams have gone to zero.
//
// state   | meaning
// IDLE    | waiting for an operand pair, in_ready high
// RUN     | streaming one unary frame into the result counters
// DONE    | result presented, held until out_ready
module dsc_cas_seq
  import dsc_cas_pkg::*;
#(
  parameter int BITS = BITS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] a_new,
  output logic [BITS-1:0] b_new,
  output logic            busy
);

  state_e          state_q, state_d;
  logic [BITS-1:0] a_q, a_d, b_q, b_d;
  logic [BITS-1:0] max_cnt_q, max_cnt_d, min_cnt_q, min_cnt_d;
  logic            gen_clr, gen_en;
  logic            sn_a, sn_b, last;

  dsc_unary_gen #(.BITS(BITS)) u_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (gen_clr),
    .en   (gen_en),
    .a    (a_q),
    .b    (b_q),
    .sn_a (sn_a),
    .sn_b (sn_b),
    .last (last)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    max_cnt_d = max_cnt_q;
    min_cnt_d = min_cnt_q;
    gen_clr   = 1'b0;
    gen_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d       = a;
          b_d       = b;
          max_cnt_d = '0;
          min_cnt_d = '0;
          gen_clr   = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        gen_en    = 1'b1;
        max_cnt_d = max_cnt_q + BITS'(sn_a | sn_b);
        min_cnt_d = min_cnt_q + BITS'(sn_a & sn_b);
`ifdef DSC_CAS_EARLY_TERM_EN
        // Streams are monotone: once both are zero nothing more can be counted.
        if (!(sn_a | sn_b) || last)
          state_d = ST_DONE;
`else
        if (last)
          state_d = ST_DONE;
`endif
      end
      ST_DONE: begin
        if (out_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      max_cnt_q <= '0;
      min_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      max_cnt_q <= max_cnt_d;
      min_cnt_q <= min_cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN);
  assign a_new     = max_cnt_q;
  assign b_new     = min_cnt_q;

endmodule

// File: tb/tb_dsc_cas_seq.sv
// Self-checking bench for dsc_cas_seq: directed boundaries plus random pairs
// against an arithmetic max/min and latency model.
module tb_dsc_cas_seq;

  localparam int BITS = 8;
  localparam int FRAME = 1 << BITS;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] a, b;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] a_new, b_new;
  logic            busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dsc_cas_seq #(.BITS(BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_new     (a_new),
    .b_new     (b_new),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_lat(input int x, input int y);
    int m;
    m = (x > y) ? x : y;
`ifdef DSC_CAS_EARLY_TERM_EN
    return m + 2;
`else
    return FRAME + 1;
`endif
  endfunction

  // Present one pair, return cycles from the handshake cycle to out_valid.
  task automatic launch(input int x, input int y, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 1000) begin
      tick();
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    a = BITS'(x);
    b = BITS'(y);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 2 * FRAME) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_pair(input string tag, input int x, input int y, input bit chk_lat);
    int lat, emax, emin;
    emax = (x > y) ? x : y;
    emin = (x > y) ? y : x;
    launch(x, y, lat);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_max"}, a_new, emax);
    chk({tag, "_min"}, b_new, emin);
    chk({tag, "_order"}, {31'd0, (a_new >= b_new)}, 32'd1);
    if (chk_lat)
      chk({tag, "_lat"}, lat, model_lat(x, y));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int lat, hold_a, hold_b, seen, x, y;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (3) tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_a_new", a_new, 0);
    chk("rst_b_new", b_new, 0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick();

    run_pair("p200_37", 200, 37, 1'b1);
    run_pair("p37_200", 37, 200, 1'b1);
    run_pair("zero", 0, 0, 1'b1);
    run_pair("full", 255, 255, 1'b1);
    run_pair("max_zero", 255, 0, 1'b1);
    run_pair("zero_max", 0, 255, 1'b1);

    // Backpressure with a competing request that must be ignored.
    launch(120, 140, lat);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    hold_a = a_new;
    hold_b = b_new;
    chk("bp_max", hold_a, 140);
    chk("bp_min", hold_b, 120);
    a = 8'd3;
    b = 8'd250;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_a", a_new, hold_a);
      chk("bp_hold_b", b_new, hold_b);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_busy", {31'd0, busy}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a frame.
    a = 8'd250;
    b = 8'd240;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (100) tick();
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_idle_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_idle_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    for (int i = 0; i < FRAME + 20; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("mid_no_valid", seen, 0);
    run_pair("after_rst", 9, 4, 1'b1);

    for (int i = 0; i < 200; i++) begin
      x = $urandom_range(0, FRAME - 1);
      y = $urandom_range(0, FRAME - 1);
      if (i % 17 == 0) y = x;
      run_pair("rnd", x, y, 1'b1);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
